sp_ram_ctrl: RTL and testbench

- Bus master for the team's 16x8 single-port RAM with a shared bidirectional data bus (we/addr/data).
- Converts a valid/ready request stream (read or write) into correctly sequenced RAM cycles.
- Owns tristate turnaround and captures read data.
- Sits between the datapath and the RAM macro, one instance per RAM.

---
 rtl/sp_ram_ctrl_if.sv | 25 ++
 rtl/sp_ram_ctrl.sv | 106 ++++++++++
 tb/tb_sp_ram_ctrl.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/sp_ram_ctrl_if.sv
// Request/response handshake between the datapath (master) and sp_ram_ctrl (slave).
interface sp_ram_ctrl_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4
);
   logic              req_valid;
   logic              req_ready;
   logic              req_wr;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              resp_valid;
   logic              resp_wr;
   logic [DATA_W-1:0] resp_rdata;
   logic              resp_err;

   modport master (
      output req_valid, req_wr, req_addr, req_wdata,
      input  req_ready, resp_valid, resp_wr, resp_rdata, resp_err
   );

   modport slave (
      input  req_valid, req_wr, req_addr, req_wdata,
      output req_ready, resp_valid, resp_wr, resp_rdata, resp_err
   );
endinterface

// File: rtl/sp_ram_ctrl.sv
// Bus master for a single-port RAM with a shared bidirectional data bus.
// Define SP_RAM_CTRL_VERIFY_EN to read back every write and flag mismatches on resp_err.
module sp_ram_ctrl #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   sp_ram_ctrl_if.slave      bus,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   inout  wire  [DATA_W-1:0] ram_data
);

`ifdef SP_RAM_CTRL_VERIFY_EN
   typedef enum logic [2:0] {IDLE, WRITE, READ, CAPTURE, VREAD, VCAP} state_t;
`else
   typedef enum logic [2:0] {IDLE, WRITE, READ, CAPTURE} state_t;
`endif

   state_t            state;
   logic [DATA_W-1:0] wdata_q;

   // Write data is only meaningful while ram_we is high, so it needs no reset.
   always_ff @(posedge clk) begin
      if (bus.req_valid && bus.req_ready) wdata_q <= bus.req_wdata;
   end

   // ram_we is the drive enable: the RAM owns the bus whenever we=0.
   assign ram_data = ram_we ? wdata_q : {DATA_W{1'bz}};

`ifndef SP_RAM_CTRL_VERIFY_EN
   assign bus.resp_err = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         bus.req_ready  <= 1'b0;
         bus.resp_valid <= 1'b0;
         bus.resp_wr    <= 1'b0;
         bus.resp_rdata <= '0;
`ifdef SP_RAM_CTRL_VERIFY_EN
         bus.resp_err   <= 1'b0;
`endif
         ram_we         <= 1'b0;
         ram_addr       <= '0;
      end else begin
         bus.resp_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.req_valid && bus.req_ready) begin
                  bus.req_ready <= 1'b0;
                  ram_addr      <= bus.req_addr;
                  ram_we        <= bus.req_wr;
                  state         <= bus.req_wr ? WRITE : READ;
               end else begin
                  bus.req_ready <= 1'b1;
               end
            end
            WRITE: begin
               ram_we <= 1'b0;
`ifdef SP_RAM_CTRL_VERIFY_EN
               state  <= VREAD;
`else
               bus.resp_valid <= 1'b1;
               bus.resp_wr    <= 1'b1;
               bus.req_ready  <= 1'b1;
               state          <= IDLE;
`endif
            end
            READ: begin
               state <= CAPTURE;
            end
            CAPTURE: begin
               bus.resp_rdata <= ram_data;
               bus.resp_valid <= 1'b1;
               bus.resp_wr    <= 1'b0;
`ifdef SP_RAM_CTRL_VERIFY_EN
               bus.resp_err   <= 1'b0;
`endif
               bus.req_ready  <= 1'b1;
               state          <= IDLE;
            end
`ifdef SP_RAM_CTRL_VERIFY_EN
            VREAD: begin
               state <= VCAP;
            end
            VCAP: begin
               bus.resp_valid <= 1'b1;
               bus.resp_wr    <= 1'b1;
               bus.resp_err   <= (ram_data != wdata_q);
               bus.req_ready  <= 1'b1;
               state          <= IDLE;
            end
`endif
            default: begin
               ram_we        <= 1'b0;
               bus.req_ready <= 1'b1;
               state         <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sp_ram_ctrl.sv
// Scoreboard bench for sp_ram_ctrl with a behavioural 16x8 single-port RAM on the shared bus.
module tb_sp_ram_ctrl;
   localparam int DW = 8;
   localparam int AW = 4;
`ifdef SP_RAM_CTRL_VERIFY_EN
   localparam int WLAT = 3;
`else
   localparam int WLAT = 1;
`endif
   localparam int RLAT = 2;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          ram_we;
   logic [AW-1:0] ram_addr;
   wire  [DW-1:0] ram_data;

   sp_ram_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) ifc ();

   sp_ram_ctrl #(.DATA_W(DW), .ADDR_W(AW)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus      (ifc),
      .ram_we   (ram_we),
      .ram_addr (ram_addr),
      .ram_data (ram_data)
   );

   always #5 clk = ~clk;

   // RAM model: registered read, drives the bus whenever we=0; stuck_mask forces bits to 0 on write.
   logic [DW-1:0] mem [16];
   logic [DW-1:0] ram_q;
   logic [DW-1:0] stuck_mask;
   assign ram_data = ram_we ? {DW{1'bz}} : ram_q;
   always @(posedge clk) begin
      if (ram_we) mem[ram_addr] <= ram_data & ~stuck_mask;
      ram_q <= mem[ram_addr];
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      bit            wr;
      logic [DW-1:0] rd;
      bit            err;
      int            acc;
      int            lat;
   } exp_t;
   exp_t          sb[$];
   exp_t          e;
   int            total = 0;
   int            passed = 0;
   logic [DW-1:0] cur_wdata = '0;
   logic [DW-1:0] last_rd = '0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, req, cyc);
      else passed++;
   endtask

   // Monitor: bus ownership every cycle, scoreboard pop on each response pulse.
   always @(negedge clk) begin
      if (rst_n) begin
         if (ram_we) chk("bus_wdata", 32'(ram_data), 32'(cur_wdata));
         else        chk("bus_ram",   32'(ram_data), 32'(ram_q));
         if (ifc.resp_valid) begin
            chk("resp_expected", 32'(sb.size() > 0), 32'(1));
            if (sb.size() > 0) begin
               e = sb.pop_front();
               chk("resp_wr",    32'(ifc.resp_wr),    32'(e.wr));
               chk("resp_rdata", 32'(ifc.resp_rdata), 32'(e.rd));
               chk("resp_err",   32'(ifc.resp_err),   32'(e.err));
               chk("resp_lat",   32'(cyc - e.acc),    32'(e.lat));
            end
         end
      end
   end

   // For reads, d is the hand-computed expected read data.
   task automatic issue(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input bit eerr, output int acc);
      exp_t x;
      int   n;
      acc = -1;
      @(negedge clk);
      ifc.req_valid = 1'b1;
      ifc.req_wr    = wr;
      ifc.req_addr  = a;
      ifc.req_wdata = wr ? d : 8'h00;
      n = 0;
      while (!ifc.req_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!ifc.req_ready) begin
         chk("req_ready_timeout", 32'(ifc.req_ready), 32'(1));
         ifc.req_valid = 1'b0;
         return;
      end
      acc   = cyc + 1;
      x.wr  = wr;
      x.err = eerr;
      x.acc = acc;
      if (wr) begin
         cur_wdata = d;
         x.rd  = last_rd;
         x.lat = WLAT;
      end else begin
         last_rd = d;
         x.rd  = d;
         x.lat = RLAT;
      end
      sb.push_back(x);
      @(posedge clk);
   endtask

   task automatic idle();
      @(negedge clk);
      ifc.req_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() > 0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("drain", 32'(sb.size()), 32'(0));
   endtask

   initial begin
      int aw1, ar1, aw2, ar2, a;
      for (int i = 0; i < 16; i++) mem[i] = 8'hC0 | 8'(i);
      ram_q = 8'h00;
      stuck_mask = 8'h00;
      ifc.req_valid = 1'b0;
      ifc.req_wr    = 1'b0;
      ifc.req_addr  = '0;
      ifc.req_wdata = '0;

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_req_ready",  32'(ifc.req_ready),  32'(0));
      chk("rst_resp_valid", 32'(ifc.resp_valid), 32'(0));
      chk("rst_resp_wr",    32'(ifc.resp_wr),    32'(0));
      chk("rst_resp_rdata", 32'(ifc.resp_rdata), 32'(0));
      chk("rst_resp_err",   32'(ifc.resp_err),   32'(0));
      chk("rst_ram_we",     32'(ram_we),         32'(0));
      chk("rst_ram_addr",   32'(ram_addr),       32'(0));
      rst_n = 1'b1;
      @(negedge clk);
      chk("ready_after_rst", 32'(ifc.req_ready), 32'(1));

      // Reset asserted mid-WRITE: drive released at once, no commit, no response
      ifc.req_valid = 1'b1;
      ifc.req_wr    = 1'b1;
      ifc.req_addr  = 4'd3;
      ifc.req_wdata = 8'hA5;
      cur_wdata     = 8'hA5;
      @(posedge clk);
      @(negedge clk);
      ifc.req_valid = 1'b0;
      chk("mid_we",   32'(ram_we),   32'(1));
      chk("mid_addr", 32'(ram_addr), 32'(3));
      rst_n = 1'b0;
      #1;
      chk("arst_we",         32'(ram_we),         32'(0));
      chk("arst_bus_free",   32'(ram_data),       32'(ram_q));
      chk("arst_resp_valid", 32'(ifc.resp_valid), 32'(0));
      chk("arst_req_ready",  32'(ifc.req_ready),  32'(0));
      @(negedge clk);
      chk("arst_no_commit",  32'(mem[3]),         32'(8'hC3));
      rst_n = 1'b1;
      @(negedge clk);
      chk("ready_after_arst", 32'(ifc.req_ready), 32'(1));

      // Write then read back
      issue(1'b1, 4'd5, 8'h3C, 1'b0, a);
      issue(1'b0, 4'd5, 8'h3C, 1'b0, a);
      idle();
      drain();

      // Boundary addresses
      issue(1'b1, 4'h0, 8'h11, 1'b0, a);
      issue(1'b1, 4'hF, 8'hEE, 1'b0, a);
      issue(1'b0, 4'h0, 8'h11, 1'b0, a);
      issue(1'b0, 4'hF, 8'hEE, 1'b0, a);
      idle();
      drain();

      // Continuous req_valid, alternating write/read
      issue(1'b1, 4'd2, 8'h55, 1'b0, aw1);
      issue(1'b0, 4'd2, 8'h55, 1'b0, ar1);
      issue(1'b1, 4'd2, 8'h55, 1'b0, aw2);
      issue(1'b0, 4'd2, 8'h55, 1'b0, ar2);
      idle();
      drain();
      chk("gap_w_to_r",  32'(ar1 - aw1), 32'(WLAT + 1));
      chk("gap_pair",    32'(aw2 - aw1), 32'(WLAT + RLAT + 2));
      chk("gap_w_to_r2", 32'(ar2 - aw2), 32'(WLAT + 1));

      // Read data held across a write; then read-after-write
      issue(1'b0, 4'd5, 8'h3C, 1'b0, a);
      issue(1'b1, 4'd7, 8'h99, 1'b0, a);
      idle();
      drain();
      chk("hold_rdata", 32'(ifc.resp_rdata), 32'(8'h3C));
      issue(1'b0, 4'd7, 8'h99, 1'b0, a);
      idle();
      drain();

`ifdef SP_RAM_CTRL_VERIFY_EN
      // Stuck-at-0 on bit 0 of the RAM
      stuck_mask = 8'h01;
      issue(1'b1, 4'd1, 8'h01, 1'b1, a);
      issue(1'b1, 4'd1, 8'h02, 1'b0, a);
      idle();
      drain();
      stuck_mask = 8'h00;
`endif

      repeat (3) @(negedge clk);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
      $fatal(1);
   end

endmodule
